// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_check
// Purpose  : UART receive-frame checker. Follows frame position from the
//            oversampler's per-bit strobe, assembles the data word LSB-first,
//            computes parity serially and checks start/parity/stop bits.
//            Reports per-frame status and keeps saturating error counters.
// Ports    : CLK, RST (async, active-low)
//            bit_vld, sampled_bit        - per-bit strobe and sampled value
//            PAR_EN, PAR_TYP, STOP2      - frame config, latched at start bit
//            err_clr                     - synchronous clear of both counters
//            frm_done, P_DATA            - frame complete pulse, data word
//            par_err, stp_err            - status of the last frame
//            strt_glitch                 - start bit sampled 1, frame aborted
//            par_err_cnt, stp_err_cnt    - saturating error counters
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    input  logic                  err_clr,
    output logic                  frm_done,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP1  = 3'd3,
        S_STOP2  = 3'd4
    } state_t;

    localparam int                   c_BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BCW-1:0]     c_LAST_BIT = c_BCW'(DATA_WIDTH - 1);
    localparam logic [c_BCW-1:0]     c_BIT_ONE  = c_BCW'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_BCW-1:0]        r_bit_cnt;
    logic                    r_acc;
    logic                    r_par_en;
    logic [1:0]              r_par_typ;
    logic                    r_stop2;
    logic                    r_par_bad;
    logic                    r_stop_bad;

    logic                    w_start;
    logic                    w_glitch;
    logic                    w_shift;
    logic                    w_par_chk;
    logic                    w_stop_smp;
    logic                    w_done;
    logic                    w_par_exp;
    logic                    w_stop_bad;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-strobe action decode; nothing moves without bit_vld
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_glitch    = 1'b0;
        w_shift     = 1'b0;
        w_par_chk   = 1'b0;
        w_stop_smp  = 1'b0;
        w_done      = 1'b0;
        if (bit_vld) begin
            case (r_state)
                S_IDLE: begin
                    if (sampled_bit) begin
                        w_glitch = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    w_par_chk   = 1'b1;
                    w_state_nxt = S_STOP1;
                end
                S_STOP1: begin
                    w_stop_smp = 1'b1;
                    if (r_stop2) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_STOP2: begin
                    w_stop_smp  = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Expected parity bit from the latched parity type
    always_comb begin
        case (r_par_typ)
            2'b00:   w_par_exp = r_acc;
            2'b01:   w_par_exp = ~r_acc;
            2'b10:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    // Stop flag including the bit being sampled now, so the completing edge
    // can publish it without waiting for r_stop_bad to update.
    assign w_stop_bad = ~sampled_bit | ((r_state == S_STOP2) & r_stop_bad);

    // Frame datapath and registered status outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_acc       <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 2'b00;
            r_stop2     <= 1'b0;
            r_par_bad   <= 1'b0;
            r_stop_bad  <= 1'b0;
            P_DATA      <= '0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            frm_done    <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            frm_done    <= w_done;
            strt_glitch <= w_glitch;
            if (w_start) begin
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_acc      <= 1'b0;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_stop2    <= STOP2;
                r_par_bad  <= 1'b0;
                r_stop_bad <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                r_acc     <= r_acc ^ sampled_bit;
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end
            if (w_par_chk) begin
                r_par_bad <= sampled_bit ^ w_par_exp;
            end
            if (w_stop_smp) begin
                r_stop_bad <= w_stop_bad;
            end
            if (w_done) begin
                P_DATA  <= r_shift;
                par_err <= r_par_en & r_par_bad;
                stp_err <= w_stop_bad;
            end
        end
    end

    // Error counters step on the frm_done cycle; err_clr has priority
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (err_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (frm_done && par_err && (par_err_cnt != c_CNT_MAX)) begin
                par_err_cnt <= par_err_cnt + c_CNT_ONE;
            end
            if (frm_done && stp_err && (stp_err_cnt != c_CNT_MAX)) begin
                stp_err_cnt <= stp_err_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
